divider_job_sequencer: RTL and testbench

//  Upstream front-end for the 8-bit restoring divider core (start/ready control, dividend/divisor buses).

---
 rtl/divider_job_sequencer.sv | 141 ++++++++++++++
 tb/tb_divider_job_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_job_sequencer.sv
// Job front-end for the restoring divider core: accepts dividend/divisor jobs,
// launches the core, and returns quotient/remainder over a valid/ready output.
module divider_job_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             div_st,
    output logic [WIDTH-1:0] div_q_bus,
    output logic [WIDTH-1:0] div_m_bus,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] div_a_bus,
    input  logic [WIDTH-1:0] div_qo_bus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_dbz,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              div_st_q;
    logic [WIDTH-1:0]  div_q_bus_q;
    logic [WIDTH-1:0]  div_m_bus_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_quot_q;
    logic [WIDTH-1:0]  out_rem_q;
    logic              out_dbz_q;
    logic              err_timeout_q;
    logic              cnt_last;

    // Counter saturates at TIMEOUT-1; timeout wins over a WAIT_BUSY->WAIT_DONE move on that cycle.
    assign cnt_last = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            div_st_q      <= 1'b0;
            div_q_bus_q   <= '0;
            div_m_bus_q   <= '0;
            out_valid_q   <= 1'b0;
            out_quot_q    <= '0;
            out_rem_q     <= '0;
            out_dbz_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        div_q_bus_q <= in_dividend;
                        div_m_bus_q <= in_divisor;
                        if (in_divisor == '0) begin
                            out_quot_q  <= '1;
                            out_rem_q   <= in_dividend;
                            out_dbz_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            div_st_q <= 1'b1;
                            state_q  <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    div_st_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (cnt_last) begin
                        err_timeout_q <= 1'b1;
                        out_quot_q    <= '0;
                        out_rem_q     <= '0;
                        out_dbz_q     <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state_q       <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (!div_ready) begin
                            state_q <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (div_ready) begin
                        out_quot_q  <= div_qo_bus;
                        out_rem_q   <= div_a_bus;
                        out_dbz_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (cnt_last) begin
                        err_timeout_q <= 1'b1;
                        out_quot_q    <= '0;
                        out_rem_q     <= '0;
                        out_dbz_q     <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state_q       <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign div_st      = div_st_q;
    assign div_q_bus   = div_q_bus_q;
    assign div_m_bus   = div_m_bus_q;
    assign out_valid   = out_valid_q;
    assign out_quot    = out_quot_q;
    assign out_rem     = out_rem_q;
    assign out_dbz     = out_dbz_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_divider_job_sequencer.sv
// Scoreboard bench for divider_job_sequencer with a behavioural divider core model.
module tb_divider_job_sequencer;

    localparam int unsigned W   = 8;
    localparam int unsigned TO  = 20;
    localparam int          LAT = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         div_st;
    logic [W-1:0] div_q_bus;
    logic [W-1:0] div_m_bus;
    logic         div_ready;
    logic [W-1:0] div_a_bus;
    logic [W-1:0] div_qo_bus;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quot;
    logic [W-1:0] out_rem;
    logic         out_dbz;
    logic         err_timeout;

    divider_job_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_st(div_st), .div_q_bus(div_q_bus), .div_m_bus(div_m_bus),
        .div_ready(div_ready), .div_a_bus(div_a_bus), .div_qo_bus(div_qo_bus),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quot(out_quot), .out_rem(out_rem), .out_dbz(out_dbz),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   st_count = 0;
    int   results_seen = 0;
    logic stub = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dbz, input logic err);
        exp_t x;
        x.q = q; x.r = r; x.dbz = dbz; x.err = err;
        return x;
    endfunction

    // Core model: drops ready after a start, finishes LAT cycles later, restarts on rst.
    initial begin : core_model
        logic [W-1:0] opa, opb;
        div_ready  = 1'b1;
        div_qo_bus = '0;
        div_a_bus  = '0;
        forever begin
            @(negedge clk);
            if (!rst && !stub && div_st) begin
                div_ready = 1'b0;
                opa = div_q_bus;
                opb = div_m_bus;
                for (int i = 0; i < LAT; i++) begin
                    @(negedge clk);
                    if (rst) break;
                end
                if (!rst) begin
                    div_qo_bus = opa / opb;
                    div_a_bus  = opa % opb;
                end
                div_ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && div_st) st_count++;
            if (!rst && out_valid) begin
                chk("in_ready_low_while_valid", in_ready, 0);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_result: got q=%0d r=%0d, expected no result", out_quot, out_rem);
                    end else begin
                        e = sb.pop_front();
                        chk("out_quot", out_quot, e.q);
                        chk("out_rem", out_rem, e.r);
                        chk("out_dbz", out_dbz, e.dbz);
                        chk("err_timeout", err_timeout, e.err);
                    end
                    results_seen++;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        in_dividend = a;
        in_divisor  = b;
        in_valid    = 1'b1;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 300) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: got no in_ready, expected accept of %0d/%0d", a, b);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (results_seen < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (results_seen < n) begin
            chk("result_wait_timeout", results_seen, n);
        end else begin
            #1;
            chk("in_ready_after_accept", in_ready, 1);
            chk("out_valid_drop", out_valid, 0);
        end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin : stimulus
        int st0;
        int k;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_div_st", div_st, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_quot", out_quot, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;

        // 1) 200/7
        st0 = st_count;
        sb.push_back(mk(8'd28, 8'd4, 1'b0, 1'b0));
        send(8'd200, 8'd7);
        chk("t1_div_q_bus", div_q_bus, 200);
        chk("t1_div_m_bus", div_m_bus, 7);
        wait_results(1);
        chk("t1_st_pulses", st_count - st0, 1);

        // 2) 13/0 short-circuit
        st0 = st_count;
        sb.push_back(mk(8'hFF, 8'd13, 1'b1, 1'b0));
        send(8'd13, 8'd0);
        chk("t2_valid_cycle1", out_valid, 1);
        wait_results(2);
        chk("t2_no_start", st_count - st0, 0);

        // 3) 255/1 with downstream stalled
        out_ready = 1'b0;
        sb.push_back(mk(8'd255, 8'd0, 1'b0, 1'b0));
        send(8'd255, 8'd1);
        wait_valid(k);
        chk("t3_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_in_ready", in_ready, 0);
            chk("t3_hold_quot", out_quot, 255);
            chk("t3_hold_rem", out_rem, 0);
            chk("t3_hold_q_bus", div_q_bus, 255);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_results(3);

        // 4) back-to-back 100/3 then 9/10
        sb.push_back(mk(8'd33, 8'd1, 1'b0, 1'b0));
        sb.push_back(mk(8'd0, 8'd9, 1'b0, 1'b0));
        send(8'd100, 8'd3);
        send(8'd9, 8'd10);
        chk("t4_first_done_before_second", results_seen, 3 + 1);
        wait_results(5);

        // 5) core never drops ready
        stub = 1'b1;
        sb.push_back(mk(8'd0, 8'd0, 1'b0, 1'b1));
        send(8'd50, 8'd3);
        wait_valid(k);
        chk("t5_timeout_window", (k >= TO && k <= TO + 2), 1);
        chk("t5_err_with_valid", err_timeout, 1);
        wait_results(6);
        chk("t5_err_sticky", err_timeout, 1);
        stub = 1'b0;
        @(posedge clk);
        #1;

        // 6) reset in WAIT_DONE of 77/5, then rerun
        send(8'd77, 8'd5);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_div_st", div_st, 0);
        chk("t6_rst_q_bus", div_q_bus, 0);
        chk("t6_rst_m_bus", div_m_bus, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_err", err_timeout, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_in_ready_release", in_ready, 1);
        @(posedge clk);
        #1;
        sb.push_back(mk(8'd15, 8'd2, 1'b0, 1'b0));
        send(8'd77, 8'd5);
        wait_results(7);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected end of stimulus");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
